fp_accumulate_driver: RTL and testbench

- Initiator-side counterpart to the team's multi-cycle floating-point adder.
- Accepts a stream of IEEE-style floats framed by a last flag and drives the adder's a/b/valid operand interface one add at a time.
- Collects each adder result and presents the final sum of the frame on a valid/ready output port.
- Sits between the layer datapath (per-neuron partial products) and the shared adder instance, which lives outside this block.

---
 rtl/fp_accumulate_driver_pkg.sv | 16 +
 rtl/fp_accumulate_driver_if.sv | 28 ++
 rtl/fp_accumulate_driver.sv | 81 ++++++++
 tb/tb_fp_accumulate_driver.sv | 310 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fp_accumulate_driver_pkg.sv
// fp_accumulate_driver_pkg: float format constants and state encoding shared by the accumulate driver, adder wrapper and bench.
package fp_accumulate_driver_pkg;
    localparam int FP_N = 32;
    localparam int FP_EXPONENT = 8;
    localparam int FP_FRACTION = 23;
    localparam int FP_BIAS = 127;
    localparam logic [31:0] FP_QNAN = 32'hFFC0_0000;
    localparam logic [31:0] FP_POS_ZERO = 32'h0000_0000;
    localparam logic [31:0] FP_NEG_ZERO = 32'h8000_0000;
    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        ACC_WAIT = 2'd1,
        ADD_WAIT = 2'd2,
        OUT      = 2'd3
    } state_t;
endpackage

// File: rtl/fp_accumulate_driver_if.sv
// fp_accumulate_driver_if: operand stream, adder request/response and sum output of the accumulate driver.
interface fp_accumulate_driver_if #(
    parameter int N = 32,
    parameter int CNT_W = 16
);
    logic [N-1:0]     in_data;
    logic             in_valid;
    logic             in_last;
    logic             in_ready;
    logic [N-1:0]     add_a;
    logic [N-1:0]     add_b;
    logic             add_valid;
    logic [N-1:0]     add_z;
    logic             add_z_valid;
    logic [N-1:0]     out_sum;
    logic [CNT_W-1:0] out_count;
    logic             out_valid;
    logic             out_ready;
    logic             err_timeout;
    modport slave (
        input  in_data, in_valid, in_last, add_z, add_z_valid, out_ready,
        output in_ready, add_a, add_b, add_valid, out_sum, out_count, out_valid, err_timeout
    );
    modport master (
        output in_data, in_valid, in_last, add_z, add_z_valid, out_ready,
        input  in_ready, add_a, add_b, add_valid, out_sum, out_count, out_valid, err_timeout
    );
endinterface

// File: rtl/fp_accumulate_driver.sv
// fp_accumulate_driver: folds a framed float stream through an external adder one add at a time and presents the frame sum.
module fp_accumulate_driver
    import fp_accumulate_driver_pkg::*;
#(
    parameter int N = FP_N,
    parameter int EXPONENT = FP_EXPONENT,
    parameter int FRACTION = FP_FRACTION,
    parameter int CNT_W = 16,
    parameter int TIMEOUT = 64
) (
    input logic clk,
    input logic rst,
    fp_accumulate_driver_if.slave bus
);
    localparam int WD_W = $clog2(TIMEOUT + 1);
    localparam logic [N-1:0] QNAN = {1'b1, {EXPONENT{1'b1}}, 1'b1, {(FRACTION-1){1'b0}}};
    state_t r_state, w_next;
    logic [N-1:0] r_acc, r_add_a, r_add_b;
    logic [CNT_W-1:0] r_cnt;
    logic [WD_W-1:0] r_wd;
    logic r_add_valid, r_last, r_err;
    logic w_in_ready, w_xfer, w_result, w_timeout;
    assign w_in_ready = !rst && (r_state == IDLE || r_state == ACC_WAIT);
    assign w_xfer = bus.in_valid && w_in_ready;
    assign w_result = r_state == ADD_WAIT && bus.add_z_valid;
    // A result arriving on the last watchdog cycle still wins over the timeout.
    assign w_timeout = r_state == ADD_WAIT && !bus.add_z_valid && r_wd == WD_W'(TIMEOUT - 1);
    always_ff @(posedge clk) begin
        if (rst) r_state <= IDLE;
        else r_state <= w_next;
    end
    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:     w_next = w_xfer ? (bus.in_last ? OUT : ACC_WAIT) : IDLE;
            ACC_WAIT: w_next = w_xfer ? ADD_WAIT : ACC_WAIT;
            ADD_WAIT: w_next = w_result ? (r_last ? OUT : ACC_WAIT) : (w_timeout ? OUT : ADD_WAIT);
            default:  w_next = bus.out_ready ? IDLE : OUT;
        endcase
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            r_acc <= '0;
            r_add_a <= '0;
            r_add_b <= '0;
            r_cnt <= '0;
            r_wd <= '0;
            r_add_valid <= 1'b0;
            r_last <= 1'b0;
            r_err <= 1'b0;
        end else begin
            r_add_valid <= 1'b0;
            if (w_xfer && r_state == IDLE) begin
                r_acc <= bus.in_data;
                r_cnt <= CNT_W'(1);
            end
            if (w_xfer && r_state == ACC_WAIT) begin
                r_add_a <= r_acc;
                r_add_b <= bus.in_data;
                r_add_valid <= 1'b1;
                r_last <= bus.in_last;
                r_cnt <= r_cnt + CNT_W'(r_cnt != '1);
                r_wd <= '0;
            end
            if (w_result) r_acc <= bus.add_z;
            if (w_timeout) begin
                r_err <= 1'b1;
                r_acc <= QNAN;
            end
            if (r_state == ADD_WAIT && !w_result && !w_timeout) r_wd <= r_wd + 1'b1;
        end
    end
    assign bus.in_ready = w_in_ready;
    assign bus.add_a = r_add_a;
    assign bus.add_b = r_add_b;
    assign bus.add_valid = r_add_valid;
    assign bus.out_valid = r_state == OUT;
    assign bus.out_sum = r_acc;
    assign bus.out_count = r_cnt;
    assign bus.err_timeout = r_err;
endmodule

// File: tb/tb_fp_accumulate_driver.sv
// tb_fp_accumulate_driver: drives framed float streams, emulates the external adder and checks sums against integer reference sums.
module tb_fp_accumulate_driver;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int checks = 0;
    int errors = 0;
    int add_pulses = 0;
    int stub_lat = 0;
    bit stub_on = 1'b1;
    bit inject = 1'b0;

    fp_accumulate_driver_if #(.N(32), .CNT_W(16)) bus();
    fp_accumulate_driver #(.N(32), .EXPONENT(8), .FRACTION(23), .CNT_W(16), .TIMEOUT(8)) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    always #5 clk = ~clk;

    function automatic logic [63:0] f32_to_f64(input logic [31:0] f);
        int e;
        logic [10:0] e11;
        if (f[30:0] == 31'd0) return {f[31], 63'd0};
        e = int'(f[30:23]) + 896;
        e11 = e[10:0];
        return {f[31], e11, f[22:0], 29'd0};
    endfunction

    function automatic logic [31:0] f64_to_f32(input logic [63:0] d);
        int e;
        if (d[62:0] == 63'd0) return {d[63], 31'd0};
        e = int'(d[62:52]) - 896;
        return {d[63], e[7:0], d[51:29]};
    endfunction

    function automatic logic [31:0] int_to_f32(input int v);
        return f64_to_f32($realtobits(real'(v)));
    endfunction

    function automatic logic [31:0] fadd(input logic [31:0] a, input logic [31:0] b);
        return f64_to_f32($realtobits($bitstoreal(f32_to_f64(a)) + $bitstoreal(f32_to_f64(b))));
    endfunction

    // Behavioural stand-in for the shared adder: fixed latency, optional stuck mode and spurious pulses.
    initial begin
        logic [31:0] z;
        int lat;
        bus.add_z = '0;
        bus.add_z_valid = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            bus.add_z_valid = 1'b0;
            if (bus.add_valid) begin
                add_pulses++;
                if (stub_on) begin
                    z = fadd(bus.add_a, bus.add_b);
                    lat = stub_lat;
                    for (int i = 0; i < lat; i++) begin
                        @(posedge clk);
                        #1;
                    end
                    bus.add_z = z;
                    bus.add_z_valid = 1'b1;
                end
            end else if (inject) begin
                inject = 1'b0;
                bus.add_z = 32'h7F12_3456;
                bus.add_z_valid = 1'b1;
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send_elem(input logic [31:0] d, input logic last, input int gap);
        int t = 0;
        bus.in_data = d;
        bus.in_valid = 1'b1;
        bus.in_last = last;
        while (!bus.in_ready && t < 100) begin
            tick();
            t++;
        end
        if (!bus.in_ready) begin
            checks++;
            errors++;
            $display("FAIL send_elem: in_ready never rose for operand %h", d);
        end
        tick();
        bus.in_valid = 1'b0;
        bus.in_last = 1'b0;
        repeat (gap) tick();
    endtask

    task automatic recv(input logic [31:0] exp_sum, input int exp_cnt, input int hold, input string name);
        int t = 0;
        while (!bus.out_valid && t < 300) begin
            tick();
            t++;
        end
        checks++;
        if (bus.out_valid !== 1'b1) begin
            errors++;
            $display("FAIL %s out_valid: got %b expected 1", name, bus.out_valid);
            return;
        end
        for (int i = 0; i < hold; i++) begin
            checks++;
            if (bus.out_valid !== 1'b1 || bus.out_sum !== exp_sum || bus.in_ready !== 1'b0) begin
                errors++;
                $display("FAIL %s hold: valid=%b sum=%h in_ready=%b expected 1 %h 0", name, bus.out_valid, bus.out_sum, bus.in_ready, exp_sum);
            end
            tick();
        end
        checks++;
        if (bus.out_sum !== exp_sum) begin
            errors++;
            $display("FAIL %s sum: got %h expected %h", name, bus.out_sum, exp_sum);
        end
        checks++;
        if (bus.out_count !== 16'(exp_cnt)) begin
            errors++;
            $display("FAIL %s count: got %0d expected %0d", name, bus.out_count, exp_cnt);
        end
        bus.out_ready = 1'b1;
        tick();
        bus.out_ready = 1'b0;
        checks++;
        if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1) begin
            errors++;
            $display("FAIL %s release: out_valid=%b in_ready=%b expected 0 1", name, bus.out_valid, bus.in_ready);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) tick();
        checks++;
        if (bus.in_ready !== 1'b0 || bus.out_valid !== 1'b0 || bus.add_valid !== 1'b0 || bus.err_timeout !== 1'b0) begin
            errors++;
            $display("FAIL reset flags: in_ready=%b out_valid=%b add_valid=%b err=%b expected 0 0 0 0", bus.in_ready, bus.out_valid, bus.add_valid, bus.err_timeout);
        end
        checks++;
        if (bus.out_sum !== 32'd0 || bus.out_count !== 16'd0 || bus.add_a !== 32'd0 || bus.add_b !== 32'd0) begin
            errors++;
            $display("FAIL reset data: sum=%h count=%0d a=%h b=%h expected zeros", bus.out_sum, bus.out_count, bus.add_a, bus.add_b);
        end
        rst = 1'b0;
        #1;
        checks++;
        if (bus.in_ready !== 1'b1) begin
            errors++;
            $display("FAIL reset release in_ready: got %b expected 1", bus.in_ready);
        end
    endtask

    task automatic test_three_sum();
        int p0 = add_pulses;
        stub_lat = 2;
        send_elem(32'h3F80_0000, 1'b0, 0);
        send_elem(32'h4000_0000, 1'b0, 1);
        send_elem(32'h4040_0000, 1'b1, 0);
        recv(32'h40C0_0000, 3, 0, "three_sum");
        checks++;
        if (add_pulses - p0 !== 2) begin
            errors++;
            $display("FAIL three_sum pulses: got %0d expected 2", add_pulses - p0);
        end
    endtask

    task automatic test_single();
        int p0 = add_pulses;
        send_elem(32'hBF80_0000, 1'b1, 0);
        checks++;
        if (bus.out_valid !== 1'b1) begin
            errors++;
            $display("FAIL single latency: out_valid=%b expected 1", bus.out_valid);
        end
        recv(32'hBF80_0000, 1, 0, "single");
        checks++;
        if (add_pulses != p0) begin
            errors++;
            $display("FAIL single pulses: got %0d expected 0", add_pulses - p0);
        end
    endtask

    task automatic test_backpressure();
        stub_lat = 0;
        send_elem(32'h3F80_0000, 1'b0, 0);
        send_elem(32'hBF80_0000, 1'b1, 0);
        recv(32'h0000_0000, 2, 5, "backpressure");
    endtask

    task automatic test_spurious();
        stub_lat = 1;
        send_elem(32'h3F80_0000, 1'b0, 0);
        inject = 1'b1;
        repeat (3) tick();
        send_elem(32'h4000_0000, 1'b0, 0);
        send_elem(32'h4080_0000, 1'b1, 0);
        recv(32'h40E0_0000, 3, 1, "spurious");
    endtask

    task automatic test_random();
        for (int f = 0; f < 20; f++) begin
            int len = int'($urandom_range(1, 6));
            int sum = 0;
            int p0 = add_pulses;
            for (int i = 0; i < len; i++) begin
                int v = int'($urandom_range(0, 100)) - 50;
                sum += v;
                stub_lat = int'($urandom_range(0, 4));
                send_elem(int_to_f32(v), i == len - 1, int'($urandom_range(0, 2)));
            end
            recv(int_to_f32(sum), len, int'($urandom_range(0, 3)), "random");
            checks++;
            if (add_pulses - p0 !== len - 1) begin
                errors++;
                $display("FAIL random pulses: got %0d expected %0d", add_pulses - p0, len - 1);
            end
        end
    endtask

    task automatic test_timeout();
        int k = 0;
        stub_on = 1'b0;
        send_elem(32'h3F80_0000, 1'b0, 0);
        send_elem(32'h4000_0000, 1'b0, 0);
        while (bus.err_timeout !== 1'b1 && k < 20) begin
            tick();
            k++;
        end
        checks++;
        if (k !== 8) begin
            errors++;
            $display("FAIL timeout delay: got %0d cycles expected 8", k);
        end
        checks++;
        if (bus.add_a !== 32'h3F80_0000 || bus.add_b !== 32'h4000_0000) begin
            errors++;
            $display("FAIL timeout operands held: a=%h b=%h expected 3f800000 40000000", bus.add_a, bus.add_b);
        end
        recv(32'hFFC0_0000, 2, 1, "timeout");
        stub_on = 1'b1;
        send_elem(32'h4040_0000, 1'b1, 0);
        recv(32'h4040_0000, 1, 0, "after_timeout");
        send_elem(32'h3F80_0000, 1'b0, 0);
        send_elem(32'h3F80_0000, 1'b1, 0);
        recv(32'h4000_0000, 2, 0, "after_timeout2");
        checks++;
        if (bus.err_timeout !== 1'b1) begin
            errors++;
            $display("FAIL timeout sticky: got %b expected 1", bus.err_timeout);
        end
    endtask

    task automatic test_reset_mid_frame();
        stub_on = 1'b0;
        send_elem(32'h4000_0000, 1'b0, 0);
        send_elem(32'h4000_0000, 1'b1, 0);
        repeat (2) tick();
        rst = 1'b1;
        tick();
        checks++;
        if (bus.in_ready !== 1'b0) begin
            errors++;
            $display("FAIL midreset in_ready during rst: got %b expected 0", bus.in_ready);
        end
        rst = 1'b0;
        #1;
        checks++;
        if (bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0 || bus.err_timeout !== 1'b0 || bus.add_valid !== 1'b0) begin
            errors++;
            $display("FAIL midreset flags: in_ready=%b out_valid=%b err=%b add_valid=%b expected 1 0 0 0", bus.in_ready, bus.out_valid, bus.err_timeout, bus.add_valid);
        end
        stub_on = 1'b1;
        stub_lat = 3;
        send_elem(32'h3F00_0000, 1'b0, 0);
        send_elem(32'h3F00_0000, 1'b1, 0);
        recv(32'h3F80_0000, 2, 0, "midreset");
    endtask

    initial begin
        bus.in_data = '0;
        bus.in_valid = 1'b0;
        bus.in_last = 1'b0;
        bus.out_ready = 1'b0;
        test_reset();
        test_three_sum();
        test_single();
        test_backpressure();
        test_spurious();
        test_random();
        test_timeout();
        test_reset_mid_frame();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end
endmodule
